// File: rtl/as5401_bus_bridge_if.sv
// as5401_bus_bridge_if: CPU, ROM, RAM and UART signal bundle of the AS5401 bus bridge
interface as5401_bus_bridge_if;
  logic [7:0]  cpu_out;
  logic [3:0]  cpu_nibble;
  logic [11:0] rom_addr;
  logic [7:0]  rom_data;
  logic [7:0]  ram_addr;
  logic [3:0]  ram_rdata;
  logic [3:0]  ram_wdata;
  logic        ram_we;
  logic        uart_tx;
  logic        uart_busy;
  logic        uart_ovf;
  logic        halt;
  modport slave (
    input  cpu_out, rom_data, ram_rdata,
    output cpu_nibble, rom_addr, ram_addr, ram_wdata, ram_we, uart_tx, uart_busy, uart_ovf, halt
  );
  modport master (
    output cpu_out, rom_data, ram_rdata,
    input  cpu_nibble, rom_addr, ram_addr, ram_wdata, ram_we, uart_tx, uart_busy, uart_ovf, halt
  );
endinterface

// File: rtl/as5401_bus_bridge.sv
// as5401_bus_bridge: AS5401 4-phase external bus bridge with memory-mapped UART TX; BRIDGE_HALT_EN makes byte 0xFF a sticky halt
module as5401_bus_bridge #(
  parameter logic [7:0] UART_ADDR    = 8'hEF,
  parameter int         CLKS_PER_BIT = 16,
  parameter int         FIFO_DEPTH   = 4
) (
  input logic clk,
  input logic rst,
  as5401_bus_bridge_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [AW:0]   FULL      = (AW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST_TICK = CW'(CLKS_PER_BIT - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;
  logic [1:0]    phase_q, phase_d;
  logic [11:0]   pc_q, pc_d;
  logic [7:0]    mar_q, mar_d;
  logic [7:0]    db0_q, db0_d;
  logic [7:0]    wr_addr_q, wr_addr_d;
  logic          i_q, i_d;
  logic          we_q, we_d;
  logic [3:0]    wdata_q, wdata_d;
  logic          nib_st_q, nib_st_d;
  logic [3:0]    nib_buf_q, nib_buf_d;
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          halt_q, halt_d;
  tx_state_e     st_q, st_d;
  logic [CW-1:0] tick_q, tick_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          uart_wr, byte_done, is_halt, push, pop, last;
  logic [7:0]    byte_in;
  assign uart_wr   = phase_q == 2'd3 && bus.cpu_out[5] && mar_q == UART_ADDR;
  assign byte_in   = {bus.cpu_out[3:0], nib_buf_q};
  assign byte_done = uart_wr && nib_st_q;
  assign pop       = st_q == IDLE && cnt_q != '0;
`ifdef BRIDGE_HALT_EN
  assign is_halt   = byte_done && byte_in == 8'hFF;
`else
  assign is_halt   = 1'b0;
`endif
  // a full FIFO still takes the push when the transmitter pops in the same clk
  assign push      = byte_done && !is_halt && (cnt_q != FULL || pop);
  // CPU cycle tracking: phase 1 latches DB0, phase 3 commits I/MAR/PC and schedules the RAM write
  always_comb begin
    phase_d   = phase_q + 2'd1;
    db0_d     = phase_q == 2'd1 ? bus.cpu_out : db0_q;
    i_d       = i_q;
    mar_d     = mar_q;
    pc_d      = pc_q;
    we_d      = 1'b0;
    wdata_d   = wdata_q;
    wr_addr_d = wr_addr_q;
    if (phase_q == 2'd3) begin
      i_d       = bus.cpu_out[7];
      mar_d     = bus.cpu_out[4] ? db0_q : mar_q;
      pc_d      = bus.cpu_out[6] ? {bus.cpu_out[3:0], db0_q} : pc_q + 12'd1;
      we_d      = bus.cpu_out[5];
      wdata_d   = bus.cpu_out[5] ? bus.cpu_out[3:0] : wdata_q;
      wr_addr_d = mar_q;
    end
  end
  // nibble pairing into bytes, FIFO pointers/occupancy and sticky flags
  always_comb begin
    nib_st_d  = uart_wr ? !nib_st_q : nib_st_q;
    nib_buf_d = uart_wr && !nib_st_q ? bus.cpu_out[3:0] : nib_buf_q;
    wp_d      = push ? wp_q + AW'(1) : wp_q;
    rp_d      = pop ? rp_q + AW'(1) : rp_q;
    cnt_d     = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    ovf_d     = ovf_q || (byte_done && !is_halt && !push);
    halt_d    = halt_q || is_halt;
  end
  // TX FSM: each of START, 8 DATA bits and STOP holds the line for CLKS_PER_BIT clks
  always_comb begin
    st_d   = st_q;
    bit_d  = bit_q;
    sh_d   = sh_q;
    last   = tick_q == LAST_TICK;
    tick_d = st_q == IDLE || last ? '0 : tick_q + CW'(1);
    case (st_q)
      IDLE:    if (pop) begin
                 st_d = START;
                 sh_d = fifo_mem[rp_q];
               end
      START:   if (last) begin
                 st_d  = DATA;
                 bit_d = '0;
               end
      DATA:    if (last) begin
                 sh_d  = sh_q >> 1;
                 bit_d = bit_q + 3'd1;
                 st_d  = bit_q == 3'd7 ? STOP : DATA;
               end
      STOP:    st_d = last ? IDLE : STOP;
      default: st_d = IDLE;
    endcase
  end
  // FIFO storage needs no reset: occupancy and pointers define validity
  always_ff @(posedge clk)
    if (push) fifo_mem[wp_q] <= byte_in;
  // state registers
  always_ff @(posedge clk)
    if (rst) begin
      phase_q   <= '0;
      pc_q      <= '0;
      mar_q     <= '0;
      db0_q     <= '0;
      wr_addr_q <= '0;
      i_q       <= 1'b0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      nib_st_q  <= 1'b0;
      nib_buf_q <= '0;
      wp_q      <= '0;
      rp_q      <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      halt_q    <= 1'b0;
      st_q      <= IDLE;
      tick_q    <= '0;
      bit_q     <= '0;
      sh_q      <= '0;
    end else begin
      phase_q   <= phase_d;
      pc_q      <= pc_d;
      mar_q     <= mar_d;
      db0_q     <= db0_d;
      wr_addr_q <= wr_addr_d;
      i_q       <= i_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      nib_st_q  <= nib_st_d;
      nib_buf_q <= nib_buf_d;
      wp_q      <= wp_d;
      rp_q      <= rp_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      halt_q    <= halt_d;
      st_q      <= st_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      sh_q      <= sh_d;
    end
  assign bus.cpu_nibble = phase_q == 2'd0 ? bus.rom_data[3:0] : i_q ? bus.rom_data[7:4] : bus.ram_rdata;
  assign bus.rom_addr   = pc_q;
  // during the write pulse RAM sees the MAR value from before the phase-3 update
  assign bus.ram_addr   = we_q ? wr_addr_q : mar_q;
  assign bus.ram_wdata  = wdata_q;
  assign bus.ram_we     = we_q;
  assign bus.uart_tx    = st_q == START ? 1'b0 : st_q == DATA ? sh_q[0] : 1'b1;
  assign bus.uart_busy  = cnt_q != '0 || st_q != IDLE;
  assign bus.uart_ovf   = ovf_q;
  assign bus.halt       = halt_q;
endmodule

// File: tb/tb_as5401_bus_bridge.sv
// tb_as5401_bus_bridge: random and directed stimulus checked every cycle against a behavioural bridge model
module tb_as5401_bus_bridge;
  localparam int CPB = 16;
  localparam int DEPTH = 4;
  localparam int UADDR = 8'hEF;
  logic clk = 1'b0;
  logic rst = 1'b1;
  as5401_bus_bridge_if bus();
  as5401_bus_bridge #(.UART_ADDR(8'hEF), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  int ph, pc, mar, ri, db0, nst, nbuf, we, wd, waddr, tx_on, tx_t, ovf, hlt, c, b;
  int started = 0;
  int tx_byte;
  int q[$];
  logic [7:0] rxq[$];
  int rx_cnt = -1;
  logic [9:0] rx_bits;
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic push_byte(int v);
`ifdef BRIDGE_HALT_EN
    if (v == 255) begin
      hlt = 1;
      return;
    end
`endif
    if (q.size() < DEPTH) q.push_back(v);
    else ovf = 1;
  endtask
  // reference model: one CPU bus clk per posedge, queue-based FIFO, frame timer for the serial line
  always @(posedge clk) begin
    started = 1;
    if (rst) begin
      ph = 0; pc = 0; mar = 0; ri = 0; db0 = 0; nst = 0; nbuf = 0;
      we = 0; wd = 0; waddr = 0; tx_on = 0; tx_t = 0; ovf = 0; hlt = 0;
      q.delete();
    end else begin
      c = int'(bus.cpu_out);
      if (tx_on != 0) begin
        if (tx_t == 10*CPB - 1) tx_on = 0;
        else tx_t++;
      end else if (q.size() != 0) begin
        tx_byte = q.pop_front();
        tx_on = 1;
        tx_t = 0;
      end
      we = 0;
      if (ph == 3) begin
        if (((c >> 5) & 1) != 0) begin
          we = 1;
          wd = c & 15;
          waddr = mar;
          if (mar == UADDR) begin
            if (nst == 0) begin
              nbuf = c & 15;
              nst = 1;
            end else begin
              b = ((c & 15) << 4) | nbuf;
              nst = 0;
              push_byte(b);
            end
          end
        end
        ri = (c >> 7) & 1;
        pc = ((c >> 6) & 1) != 0 ? (((c & 15) << 8) | db0) : (pc + 1) % 4096;
        if (((c >> 4) & 1) != 0) mar = db0;
      end
      if (ph == 1) db0 = c;
      ph = (ph + 1) % 4;
    end
  end
  // compare every output against the model in the middle of each clk
  always @(negedge clk) begin
    int k, line;
    if (started != 0) begin
      k = tx_t / CPB;
      line = tx_on == 0 ? 1 : k == 0 ? 0 : k == 9 ? 1 : (tx_byte >> (k - 1)) & 1;
      chk("rom_addr", int'(bus.rom_addr), pc);
      chk("ram_addr", int'(bus.ram_addr), we != 0 ? waddr : mar);
      chk("cpu_nibble", int'(bus.cpu_nibble), ph == 0 ? int'(bus.rom_data) & 15 : ri != 0 ? int'(bus.rom_data) >> 4 : int'(bus.ram_rdata));
      chk("ram_we", int'(bus.ram_we), we);
      if (we != 0) chk("ram_wdata", int'(bus.ram_wdata), wd);
      chk("uart_tx", int'(bus.uart_tx), line);
      chk("uart_busy", int'(bus.uart_busy), (q.size() != 0 || tx_on != 0) ? 1 : 0);
      chk("uart_ovf", int'(bus.uart_ovf), ovf);
      chk("halt", int'(bus.halt), hlt);
    end
  end
  // independent serial receiver sampling mid-bit
  always @(negedge clk) begin
    if (rst) rx_cnt = -1;
    else if (rx_cnt < 0) begin
      if (bus.uart_tx === 1'b0) rx_cnt = 0;
    end else begin
      if (rx_cnt % CPB == CPB/2) rx_bits[rx_cnt/CPB] = bus.uart_tx;
      if (rx_cnt == 9*CPB + CPB/2) begin
        chk("rx_start", int'(rx_bits[0]), 0);
        chk("rx_stop", int'(rx_bits[9]), 1);
        rxq.push_back(rx_bits[8:1]);
        rx_cnt = -1;
      end else rx_cnt++;
    end
  end
  task automatic drive(int v);
    bus.cpu_out = 8'(v);
    bus.rom_data = 8'($urandom);
    bus.ram_rdata = 4'($urandom);
    @(posedge clk);
    #2;
  endtask
  task automatic instr(int b1, int b3);
    while (ph != 0) drive(0);
    drive(0);
    drive(b1);
    drive(0);
    drive(b3);
  endtask
  task automatic uart_byte(int v);
    instr(0, 'h20 | (v & 15));
    instr(0, 'h20 | (v >> 4));
  endtask
  task automatic wait_rx(int n);
    int k = 0;
    while (rxq.size() < n && k < 2000) begin
      drive(0);
      k++;
    end
    checks++;
    if (rxq.size() < n) begin
      errors++;
      $display("FAIL rx_wait: got %0d frames expected %0d", rxq.size(), n);
    end
  endtask
  initial begin
    bus.cpu_out = 8'h00;
    bus.rom_data = 8'hA5;
    bus.ram_rdata = 4'h3;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    chk("rst_uart_tx", int'(bus.uart_tx), 1);
    chk("rst_halt", int'(bus.halt), 0);
    chk("rst_ovf", int'(bus.uart_ovf), 0);
    chk("rst_busy", int'(bus.uart_busy), 0);
    chk("rst_rom_addr", int'(bus.rom_addr), 'h000);
    chk("rst_ram_addr", int'(bus.ram_addr), 'h00);
    chk("rst_nibble", int'(bus.cpu_nibble), 'h5);
    instr('h34, 'h45);
    chk("jump", int'(bus.rom_addr), 'h534);
    instr('hFF, 'h4F);
    chk("jump_fff", int'(bus.rom_addr), 'hFFF);
    instr(0, 0);
    chk("pc_wrap", int'(bus.rom_addr), 'h000);
    instr('h20, 'h10);
    chk("mar_load", int'(bus.ram_addr), 'h20);
    chk("mar_no_we", int'(bus.ram_we), 0);
    instr(0, 'h27);
    chk("wr_we", int'(bus.ram_we), 1);
    chk("wr_addr", int'(bus.ram_addr), 'h20);
    chk("wr_data", int'(bus.ram_wdata), 'h7);
    rxq.delete();
    instr('hEF, 'h10);
    chk("mar_uart", int'(bus.ram_addr), 'hEF);
    uart_byte('h48);
    chk("busy_48", int'(bus.uart_busy), 1);
    wait_rx(1);
    if (rxq.size() >= 1) chk("rx_48", int'(rxq[0]), 'h48);
    repeat (CPB) drive(0);
    chk("idle_busy", int'(bus.uart_busy), 0);
    chk("idle_tx", int'(bus.uart_tx), 1);
    rxq.delete();
    for (int n = 1; n <= 6; n++) uart_byte('h11 * n);
    chk("ovf_set", int'(bus.uart_ovf), 1);
    wait_rx(5);
    for (int n = 0; n < 5; n++) if (rxq.size() > n) chk("rx_seq", int'(rxq[n]), 'h11 * (n + 1));
    repeat (CPB) drive(0);
    chk("drain_busy", int'(bus.uart_busy), 0);
    chk("rx_count", rxq.size(), 5);
    rxq.delete();
    uart_byte('hFF);
`ifdef BRIDGE_HALT_EN
    repeat (200) drive(0);
    chk("halt_set", int'(bus.halt), 1);
    chk("halt_no_frame", rxq.size(), 0);
    chk("halt_tx_idle", int'(bus.uart_tx), 1);
`else
    wait_rx(1);
    if (rxq.size() >= 1) chk("rx_ff", int'(rxq[0]), 'hFF);
    chk("no_halt", int'(bus.halt), 0);
`endif
    rst = 1'b1;
    drive(0);
    rst = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      int v;
      v = int'($urandom_range(255, 0));
      if (ph == 1 && $urandom_range(1, 0) == 1) v = UADDR;
      if (ph == 3) begin
        if ($urandom_range(9, 0) < 7) v = v & 'hBF;
        if ($urandom_range(9, 0) < 6) v = v | 'h20;
      end
      rst = $urandom_range(999, 0) == 0;
      drive(v);
      rst = 1'b0;
    end
    repeat (12*CPB) drive(0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule

// File: doc/as5401_bus_bridge.md
Name: as5401_bus_bridge

Overview:
Synthesizable external-bus bridge downstream of the AS5401 CPU's 8-bit output bus. It reproduces the CPU's 4-phase memory cycle in hardware:
- tracks the bus phase;
- latches the DB0 operand byte;
- maintains the program counter (PC), memory address register (MAR) and ROM-nibble select flag (I);
- addresses external ROM/RAM and returns nibbles to the CPU.
Writes to UART_ADDR are decoded into a memory-mapped UART transmitter with a small FIFO, replacing the simulation-only console.

Parameters:
UART_ADDR, 8'hEF, RAM address decoded as UART data port
CLKS_PER_BIT, 16, clk cycles per UART bit (>=2)
FIFO_DEPTH, 4, TX FIFO entries (power of two, >=2)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
cpu_out  in  8  CPU io_out bus
cpu_nibble  out  4  nibble to CPU io_in[5:2]
rom_addr  out  12  external ROM address (= PC)
rom_data  in  8  external ROM byte, asynchronous read
ram_addr  out  8  external RAM address (= MAR)
ram_rdata  in  4  external RAM nibble, asynchronous read
ram_wdata  out  4  RAM write data
ram_we  out  1  RAM write strobe, one clk
uart_tx  out  1  serial line, 8N1, idle high
uart_busy  out  1  FIFO non-empty or frame in progress
uart_ovf  out  1  sticky: byte dropped because FIFO full
halt  out  1  sticky halt request (optional feature)

Behaviour:
- Reset values: phase=0, PC=0, MAR=0, I=0, DB0=0, nibble_state=0, nibble_buf=0, FIFO empty, TX state IDLE.
- Output reset values: uart_tx=1, ram_we=0, uart_busy=0, uart_ovf=0, halt=0.
- Phase: 2-bit counter, +1 every clk, wraps 3->0.
- cpu_nibble (combinational):
  - phase 0: rom_data[3:0];
  - phases 1-3: I ? rom_data[7:4] : ram_rdata.
- rom_addr=PC and ram_addr=MAR, combinational from registers.
- Phase 1: DB0 <= cpu_out.
- Phase 3 updates, all registered simultaneously using old values:
  - I <= cpu_out[7];
  - MAR <= cpu_out[4] ? DB0 : MAR;
  - PC <= cpu_out[6] ? {cpu_out[3:0],DB0} : PC+1. Increment is modulo 4096 (0xFFF->0x000).
  - If cpu_out[5]: ram_we=1 for the following clk (phase 0), ram_wdata=cpu_out[3:0], address = MAR before this update. The write to RAM at MAR happens with ram_addr held at the pre-update MAR value, not the newly loaded MAR.
- UART decode: the qualifying write is cpu_out[5] at phase 3 with old MAR==UART_ADDR. The RAM write still occurs.
  - nibble_state=0: nibble_buf <= cpu_out[3:0]; nibble_state <= 1.
  - nibble_state=1: byte={cpu_out[3:0],nibble_buf}; push to FIFO; nibble_state <= 0.
  - FIFO full at push: byte dropped, uart_ovf <= 1 (sticky until rst). FIFO contents unaffected.
- FIFO: circular, FIFO_DEPTH entries, occupancy counter 0..FIFO_DEPTH. A push and a TX pop in the same clk are both honoured; a full FIFO that pops while pushing accepts the push.
- TX FSM:
  - IDLE: if FIFO non-empty, pop, load shifter, go START.
  - START: line 0.
  - DATA: 8 bits, LSB first.
  - STOP: line 1.
  - Each state or bit lasts CLKS_PER_BIT clks; STOP returns to IDLE.
  - Frame = 10*CLKS_PER_BIT clks. Back-to-back frames take one extra IDLE clk between STOP and the next START.
- uart_busy = (FIFO count!=0) || state!=IDLE.
- rst mid-frame: frame aborted, uart_tx=1 after that edge, FIFO flushed, a half-received nibble pair discarded.

Optional Feature:
Macro BRIDGE_HALT_EN.
- Defined: a completed UART byte of 8'hFF is not pushed. halt <= 1 (sticky until rst); further UART bytes are still accepted.
- Undefined: 8'hFF is pushed and transmitted like any byte; halt tied 0.

Test Plan:
1. Reset: assert rst 2 clks -> uart_tx=1, halt=0, uart_ovf=0, rom_addr=0x000, ram_addr=0x00; phase-0 cpu_nibble equals rom_data[3:0].
2. Jump: cpu_out=0x34 at phase 1, then 0x45 at phase 3 -> rom_addr=0x534 next cycle. With cpu_out=0x00 at phase 3 and PC=0xFFF -> rom_addr=0x000.
3. MAR load + write:
   - DB0=0x20, phase-3 cpu_out=0x10 -> ram_addr=0x20, no ram_we.
   - Next instruction, phase-3 cpu_out=0x27 -> ram_we pulse, ram_addr=0x20, ram_wdata=0x7.
4. UART: MAR=0xEF; writes of nibble 0x8 then 0x4 -> uart_tx frame for 0x48: start 0, bits 0,0,0,1,0,0,1,0, stop 1; each bit 16 clks; uart_busy high throughout, low after stop.
5. Overflow: push 6 bytes faster than one frame with FIFO_DEPTH=4 -> first byte transmitting plus 4 queued, 6th dropped, uart_ovf=1; transmitted sequence matches the first 5 bytes.
6. BRIDGE_HALT_EN: write nibbles 0xF, 0xF -> halt=1, uart_tx stays idle. Without the macro, byte 0xFF is transmitted and halt stays 0.
